// File: rtl/csr_pkg.sv
// Shared CSR-unit definitions: CSR addresses, CSROp encodings, the
// illegal-instruction cause code and the trap sequencer state type.
// No ports; imported by irq_controller and irq_arbiter.
package csr_pkg;

    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam logic [2:0] CSR_NONE = 3'b000;
    localparam logic [2:0] CSR_W    = 3'b001;
    localparam logic [2:0] CSR_C    = 3'b010;
    localparam logic [2:0] CSR_S    = 3'b011;
    localparam logic [2:0] CSR_TRAP = 3'b100;

    localparam logic [31:0] MCAUSE_ILLEGAL = 32'h2;

    typedef enum logic {IDLE, HANDLER} irq_state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Core <-> trap sequencer bundle.
//   core side (master) drives: stall_i, exc_i, mret_i, irq_i, mie_i
//   sequencer (slave) drives : csr_op_o, mcause_o, trap_o, ret_o,
//                              irq_ack_o, in_handler_o
interface irq_controller_if #(
    parameter int unsigned IRQ_NUM = 8
);
    logic               stall_i;
    logic               exc_i;
    logic               mret_i;
    logic [IRQ_NUM-1:0] irq_i;
    logic [31:0]        mie_i;
    logic [2:0]         csr_op_o;
    logic [31:0]        mcause_o;
    logic               trap_o;
    logic               ret_o;
    logic [IRQ_NUM-1:0] irq_ack_o;
    logic               in_handler_o;

    modport master (
        output stall_i, exc_i, mret_i, irq_i, mie_i,
        input  csr_op_o, mcause_o, trap_o, ret_o, irq_ack_o, in_handler_o
    );

    modport slave (
        input  stall_i, exc_i, mret_i, irq_i, mie_i,
        output csr_op_o, mcause_o, trap_o, ret_o, irq_ack_o, in_handler_o
    );
endinterface

// File: rtl/irq_arbiter.sv
// Combinational interrupt arbiter.
//   eligible : pending & enabled lines
//   rr_ptr   : round-robin search start (ignored in fixed-priority build)
//   grant    : one-hot winner
//   index    : binary winner
//   valid    : some line is eligible
// Build option: IRQ_RR_ARB_EN selects round-robin search from rr_ptr;
// otherwise the lowest eligible index wins.
module irq_arbiter
    import csr_pkg::*;
#(
    parameter int unsigned IRQ_NUM = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [IRQ_NUM-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IRQ_NUM-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    always_comb begin
        logic [IDX_W-1:0] pos;
        grant = '0;
        index = '0;
        valid = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < IRQ_NUM; k++) begin
`ifdef IRQ_RR_ARB_EN
            pos = IDX_W'((32'(rr_ptr) + k) % IRQ_NUM);
`else
            pos = IDX_W'(k);
`endif
            // first hit in search order wins
            if (!valid && eligible[pos]) begin
                valid      = 1'b1;
                index      = pos;
                grant[pos] = 1'b1;
            end
        end
    end

`ifndef IRQ_RR_ARB_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
`endif

endmodule

// File: rtl/irq_controller.sv
// Trap/interrupt sequencer for the CSR unit.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : stall/exception/mret/irq/mie in; CSROp, mcause,
//                  trap/ret PC-mux selects, irq ack, in-handler flag out
// Interrupt lines are edge-detected into pending bits, masked with mie
// and arbitrated; exceptions always win. Trap/ret decisions are Mealy
// (same cycle as the inputs).
// Build option: IRQ_RR_ARB_EN enables round-robin arbitration (rr_ptr).
module irq_controller
    import csr_pkg::*;
#(
    parameter int unsigned IRQ_NUM  = 8,
    parameter logic [31:0] IRQ_BASE = 32'h8000_0010
) (
    input  logic             clock,
    input  logic             reset,
    irq_controller_if.slave  bus
);

    localparam int unsigned IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    irq_state_t         state, state_next;
    logic [IRQ_NUM-1:0] irq_q;
    logic [IRQ_NUM-1:0] pending;
    logic [IRQ_NUM-1:0] eligible;
    logic [IRQ_NUM-1:0] grant;
    logic [IDX_W-1:0]   index;
    logic [IDX_W-1:0]   rr_ptr;
    logic               valid;

    // irq_q also samples while reset is held, so a line that is already
    // high when reset releases is not mistaken for a new rising edge.
    always_ff @(posedge clock) begin
        irq_q <= bus.irq_i;
    end

    // A new rising edge takes precedence over a same-cycle ack clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= (pending & ~bus.irq_ack_o) | (bus.irq_i & ~irq_q);
        end
    end

`ifdef IRQ_RR_ARB_EN
    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (|bus.irq_ack_o)
            rr_ptr <= (index == IDX_W'(IRQ_NUM - 1)) ? '0 : index + 1'b1;
    end
`else
    assign rr_ptr = '0;
`endif

    assign eligible = pending & bus.mie_i[IRQ_NUM-1:0];

    irq_arbiter #(
        .IRQ_NUM (IRQ_NUM),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .index    (index),
        .valid    (valid)
    );

    always_comb begin
        state_next    = state;
        bus.trap_o    = 1'b0;
        bus.ret_o     = 1'b0;
        bus.irq_ack_o = '0;
        bus.mcause_o  = '0;
        if (!reset && !bus.stall_i) begin
            if (bus.exc_i) begin
                bus.trap_o   = 1'b1;
                bus.mcause_o = MCAUSE_ILLEGAL;
            end else if (state == IDLE && valid) begin
                bus.trap_o    = 1'b1;
                bus.mcause_o  = IRQ_BASE + 32'(index);
                bus.irq_ack_o = grant;
                state_next    = HANDLER;
            end else if (state == HANDLER && bus.mret_i) begin
                bus.ret_o  = 1'b1;
                state_next = IDLE;
            end
        end
    end

    assign bus.csr_op_o     = bus.trap_o ? CSR_TRAP : CSR_NONE;
    assign bus.in_handler_o = (state == HANDLER);

    logic unused_mie;
    assign unused_mie = ^bus.mie_i[31:IRQ_NUM];

endmodule
